wm8731_cfg_seq: RTL and testbench
=================================

WM8731_CFG_SEQ -- requirements
Module: wm8731_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'h34, is the WM8731 7-bit address 0x1A with the write bit appended.
REQ-002 Parameter GAP_CYCLES, default 64, is the idle clocks between consecutive writes (legal range 1..255).
REQ-003 Parameter ACCEPT_TIMEOUT, default 16, is the clocks allowed for i2c_idle to fall after wr_i2c (legal range 2..255).
REQ-004 Clocking SHALL be: clk (input, 1 bit); reset reset, synchronous, active-high; clock clk.
REQ-005 reset: input, 1 bit, synchronous active-high reset.
REQ-006 start: input, 1 bit, single-cycle request to run the full configuration sequence.
REQ-007 i2c_idle: input, 1 bit, high when the downstream I2C controller is idle.
REQ-008 i2c_din: output, 24 bits, write word {DEV_ADDR, reg[6:0], data[8:0]} to the I2C controller.
REQ-009 wr_i2c: output, 1 bit, single-cycle write strobe to the I2C controller.
REQ-010 busy: output, 1 bit, high while the sequence runs.
REQ-011 done: output, 1 bit, sticky; high after all entries complete.
REQ-012 error: output, 1 bit, sticky; high after an accept timeout.
REQ-013 idx: output, 4 bits, index of the table entry in progress.

Function
REQ-014 Table (11 entries, reg/data): 0 R15/000, 1 R0/017, 2 R1/017, 3 R2/079, 4 R3/079, 5 R4/012, 6 R5/000, 7 R6/000, 8 R7/042, 9 R8/000, 10 R9/001.
REQ-015 FSM states: IDLE, LOAD, ISSUE, WAIT_ACC, WAIT_END, GAP, FIN, ERR.
REQ-016 IDLE -> LOAD on start; idx cleared to 0; done and error cleared; busy set.
REQ-017 LOAD registers i2c_din from the table at idx; advances to ISSUE next cycle.
REQ-018 ISSUE: when i2c_idle=1, assert wr_i2c for exactly one cycle and go to WAIT_ACC; otherwise hold.
REQ-019 WAIT_ACC: i2c_idle=0 -> WAIT_END; timeout counter reaching ACCEPT_TIMEOUT with i2c_idle still 1 -> ERR.
REQ-020 WAIT_END: i2c_idle=1 -> GAP, with the gap counter loaded to GAP_CYCLES.
REQ-021 GAP: counter decrements each cycle; at 0, if idx=10 go to FIN, else increment idx and go to LOAD.
REQ-022 FIN: set done, clear busy, go to IDLE.
REQ-023 ERR: set error, clear busy, go to IDLE; idx holds the failing entry.
REQ-024 i2c_din SHALL remain stable from LOAD until the cycle after i2c_idle rises in WAIT_END.
REQ-025 start while busy=1 SHALL be ignored; start in the same cycle FIN/ERR returns to IDLE SHALL be ignored.
REQ-026 wr_i2c SHALL never be asserted in any state other than ISSUE, nor for two consecutive cycles.
REQ-027 Minimum latency: start to first wr_i2c is 3 clocks (IDLE->LOAD->ISSUE, strobe registered), provided i2c_idle=1.
REQ-028 All outputs SHALL be registered; no combinational path from i2c_idle to wr_i2c.

Reset
REQ-029 On reset: state IDLE; i2c_din=0, wr_i2c=0, busy=0, done=0, error=0, idx=0; counters cleared.
REQ-030 Reset mid-transfer SHALL abort the sequence at the next edge with no further strobes; a fresh start restarts from entry 0.

Structure
REQ-031 Shared package wm8731_pkg SHALL hold register address constants R0..R9/R15, the default DEV_ADDR, table length 11, and the state encodings.
REQ-032 Sub-module wm8731_cfg_rom SHALL hold the table as a combinational 4-bit index to 16-bit {reg, data} lookup; indices 11-15 return 0.

Verification
REQ-033 Reset, start, and a model I2C holding idle low for 100 clocks per write -> 11 strobes; i2c_din sequence 341E00, 340017, 340217, 340479, 340679, 340812, 340A00, 340C00, 340E42, 341000, 341201; done=1, error=0.
REQ-034 i2c_idle held low at start for 50 clocks -> first wr_i2c appears only after i2c_idle rises; no strobe while low.
REQ-035 Model never drops i2c_idle on entry 3 -> error=1 after 16 clocks in WAIT_ACC, idx=3, busy=0, only 4 strobes total.
REQ-036 Reset asserted in WAIT_END of entry 5 -> next cycle busy=0, wr_i2c=0; a new start yields first word 341E00.
REQ-037 Second start pulse during a run -> ignored; exactly 11 strobes; consecutive strobes separated by at least 64 idle clocks.

Source files
------------

// File: rtl/wm8731_pkg.sv
// Shared constants for the WM8731 codec configuration sequencer:
// register addresses, default device address, table length and FSM encoding.
package wm8731_pkg;

    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;  // 7-bit 0x1A plus write bit
    localparam int         TABLE_LEN        = 11;
    localparam logic [3:0] LAST_IDX         = 4'(TABLE_LEN - 1);

    localparam logic [6:0] R0  = 7'd0;   // left line in
    localparam logic [6:0] R1  = 7'd1;   // right line in
    localparam logic [6:0] R2  = 7'd2;   // left headphone out
    localparam logic [6:0] R3  = 7'd3;   // right headphone out
    localparam logic [6:0] R4  = 7'd4;   // analogue path
    localparam logic [6:0] R5  = 7'd5;   // digital path
    localparam logic [6:0] R6  = 7'd6;   // power down
    localparam logic [6:0] R7  = 7'd7;   // digital audio interface format
    localparam logic [6:0] R8  = 7'd8;   // sampling control
    localparam logic [6:0] R9  = 7'd9;   // active control
    localparam logic [6:0] R15 = 7'd15;  // reset

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACC = 3'd3,
        WAIT_END = 3'd4,
        GAP      = 3'd5,
        FIN      = 3'd6,
        ERR      = 3'd7
    } state_t;

    // Packs one table entry into the 16-bit {reg[6:0], data[8:0]} control word.
    function automatic logic [15:0] cfg_entry(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/wm8731_cfg_rom.sv
// Configuration table: 4-bit entry index to 16-bit {reg, data} word.
// Indices past the end of the table read as zero.
module wm8731_cfg_rom
    import wm8731_pkg::*;
(
    input  logic [3:0]  index,
    output logic [15:0] word
);

    always_comb begin
        // NOTE: the default assignment before the case keeps every path driven,
        // so no latch is inferred for the unlisted indices.
        word = 16'h0000;
        case (index)
            4'd0:    word = cfg_entry(R15, 9'h000);  // soft reset first
            4'd1:    word = cfg_entry(R0,  9'h017);
            4'd2:    word = cfg_entry(R1,  9'h017);
            4'd3:    word = cfg_entry(R2,  9'h079);
            4'd4:    word = cfg_entry(R3,  9'h079);
            4'd5:    word = cfg_entry(R4,  9'h012);
            4'd6:    word = cfg_entry(R5,  9'h000);
            4'd7:    word = cfg_entry(R6,  9'h000);
            4'd8:    word = cfg_entry(R7,  9'h042);
            4'd9:    word = cfg_entry(R8,  9'h000);
            4'd10:   word = cfg_entry(R9,  9'h001);  // activate last
            default: word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/wm8731_cfg_seq.sv
// WM8731 power-up configuration sequencer: walks the register table and hands
// each 24-bit write word to a downstream I2C controller, one write at a time.
module wm8731_cfg_seq
    import wm8731_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR       = DEV_ADDR_DEFAULT,
    parameter int         GAP_CYCLES     = 64,
    parameter int         ACCEPT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        i2c_idle,
    output logic [23:0] i2c_din,
    output logic        wr_i2c,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  idx
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..255");
    end
    if (ACCEPT_TIMEOUT < 2 || ACCEPT_TIMEOUT > 255) begin : g_bad_timeout
        $error("ACCEPT_TIMEOUT must be in 2..255");
    end

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
    localparam logic [7:0] ACC_LAST = 8'(ACCEPT_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  acc_cnt;
    logic [7:0]  gap_cnt;
    logic [15:0] rom_word;

    wm8731_cfg_rom u_rom (
        .index (idx),
        .word  (rom_word)
    );

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch reads the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            i2c_din <= '0;
            wr_i2c  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            idx     <= '0;
            acc_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            wr_i2c <= 1'b0;  // strobe lasts a single cycle unless ISSUE re-arms it
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    i2c_din <= {DEV_ADDR, rom_word};
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (i2c_idle) begin
                        wr_i2c  <= 1'b1;
                        acc_cnt <= '0;
                        state   <= WAIT_ACC;
                    end
                end
                WAIT_ACC: begin
                    // The controller must leave idle to show it took the word.
                    if (!i2c_idle) begin
                        state <= WAIT_END;
                    end else if (acc_cnt == ACC_LAST) begin
                        state <= ERR;
                    end else begin
                        acc_cnt <= acc_cnt + 8'd1;
                    end
                end
                WAIT_END: begin
                    if (i2c_idle) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        if (idx == LAST_IDX) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    error <= 1'b1;  // idx keeps the entry that was never accepted
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_strobe_single: assert property (@(posedge clk) disable iff (reset)
        wr_i2c |=> !wr_i2c);

    a_strobe_from_issue: assert property (@(posedge clk) disable iff (reset)
        wr_i2c |-> state == WAIT_ACC);

    a_word_stable: assert property (@(posedge clk) disable iff (reset)
        (state inside {ISSUE, WAIT_ACC, WAIT_END}) |=> $stable(i2c_din));

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Scoreboard bench for wm8731_cfg_seq: the driver queues expected write words,
// a monitor pops them on each wr_i2c, and a small I2C model answers the strobes.
module tb_wm8731_cfg_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        i2c_idle;
    logic [23:0] i2c_din;
    logic        wr_i2c;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  idx;

    wm8731_cfg_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .i2c_idle (i2c_idle),
        .i2c_din  (i2c_din),
        .wr_i2c   (wr_i2c),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .idx      (idx)
    );

    localparam logic [23:0] EXP_WORDS [11] = '{
        24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
        24'h340A00, 24'h340C00, 24'h340E42, 24'h341000, 24'h341201
    };

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] exp_q[$];
    int          strobes  = 0;

    // I2C model controls
    int hold_clks  = 100;
    int refuse_idx = -1;
    bit force_low  = 0;
    int busy_cnt   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // I2C controller model: drops idle for hold_clks after each accepted strobe.
    initial begin
        i2c_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (wr_i2c && int'(idx) != refuse_idx) busy_cnt = hold_clks;
            end
            i2c_idle = !(force_low || busy_cnt > 0);
        end
    end

    // Monitor: pops the scoreboard on every strobe, checks spacing.
    initial begin
        int   cyc         = 0;
        int   last_strobe = -1;
        logic prev_wr     = 1'b0;
        logic [23:0] exp_word;
        forever begin
            @(negedge clk);
            cyc++;
            if (start && !busy && !reset) last_strobe = -1;
            if (wr_i2c) begin
                strobes++;
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check("i2c_din_word", 32'(i2c_din), 32'(exp_word));
                end
                check("strobe_not_back_to_back", 32'(prev_wr), 32'd0);
                if (last_strobe >= 0)
                    check("strobe_spacing_ge_65", 32'(cyc - last_strobe >= 65), 32'd1);
                last_strobe = cyc;
            end
            prev_wr = wr_i2c;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(EXP_WORDS[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_strobe_idx(input logic [3:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (wr_i2c && idx == want) ok = 1'b1;
        end
    endtask

    task automatic wait_not_busy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (!busy) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int base;
        int lat;
        int low_strobes;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_error",   32'(error),   32'd0);
        check("rst_idx",     32'(idx),     32'd0);
        check("rst_wr_i2c",  32'(wr_i2c),  32'd0);
        check("rst_i2c_din", 32'(i2c_din), 32'd0);
        reset = 1'b0;
        tick();

        // Full sequence with idle high at start: latency and 11 words
        base = strobes;
        push_words(11);
        start = 1'b1;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            start = 1'b0;
            lat++;
            if (wr_i2c) ok = 1'b1;
        end
        check("first_strobe_seen", 32'(ok), 32'd1);
        check("start_to_strobe_latency", 32'(lat), 32'd3);
        check("busy_during_run", 32'(busy), 32'd1);
        wait_not_busy(4000, ok);
        check("run1_finished", 32'(ok), 32'd1);
        check("run1_done",     32'(done), 32'd1);
        check("run1_error",    32'(error), 32'd0);
        check("run1_strobes",  32'(strobes - base), 32'd11);
        check("run1_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) tick();

        // Controller busy at start: no strobe until idle rises
        base = strobes;
        force_low = 1'b1;
        push_words(11);
        pulse_start();
        low_strobes = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (wr_i2c) low_strobes++;
        end
        check("no_strobe_while_low", 32'(low_strobes), 32'd0);
        check("busy_while_low", 32'(busy), 32'd1);
        check("done_cleared_on_start", 32'(done), 32'd0);
        force_low = 1'b0;
        wait_strobe_idx(4'd0, 10, ok);
        check("strobe_after_idle_rises", 32'(ok), 32'd1);
        wait_not_busy(4000, ok);
        check("run2_finished", 32'(ok), 32'd1);
        check("run2_done",     32'(done), 32'd1);
        check("run2_strobes",  32'(strobes - base), 32'd11);
        repeat (5) tick();

        // Controller never accepts entry 3: accept timeout
        base = strobes;
        refuse_idx = 3;
        push_words(4);
        pulse_start();
        wait_strobe_idx(4'd3, 3000, ok);
        check("entry3_strobe_seen", 32'(ok), 32'd1);
        repeat (16) tick();
        check("no_error_before_timeout", 32'(error), 32'd0);
        tick();
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_idx",   32'(idx),   32'd3);
        check("timeout_busy",  32'(busy),  32'd0);
        check("timeout_done",  32'(done),  32'd0);
        repeat (20) tick();
        check("timeout_strobes", 32'(strobes - base), 32'd4);
        check("timeout_queue_empty", 32'(exp_q.size()), 32'd0);
        refuse_idx = -1;

        // Reset while waiting for entry 5 to finish
        base = strobes;
        push_words(11);
        pulse_start();
        check("error_cleared_on_start", 32'(error), 32'd0);
        wait_strobe_idx(4'd5, 3000, ok);
        check("entry5_strobe_seen", 32'(ok), 32'd1);
        tick();
        tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("midrun_reset_busy",   32'(busy),   32'd0);
        check("midrun_reset_wr_i2c", 32'(wr_i2c), 32'd0);
        check("midrun_reset_idx",    32'(idx),    32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (150) tick();
        check("no_strobe_after_reset", 32'(strobes - base), 32'd6);

        // Restart from entry 0 with a second start pulse mid-run
        base = strobes;
        push_words(11);
        pulse_start();
        wait_strobe_idx(4'd2, 3000, ok);
        check("restart_entry2_seen", 32'(ok), 32'd1);
        repeat (10) tick();
        pulse_start();
        check("busy_after_second_start", 32'(busy), 32'd1);
        wait_not_busy(4000, ok);
        check("run5_finished", 32'(ok), 32'd1);
        check("run5_done",     32'(done), 32'd1);
        check("run5_strobes",  32'(strobes - base), 32'd11);
        repeat (100) tick();
        check("run5_no_rerun", 32'(strobes - base), 32'd11);
        check("run5_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
